// File: rtl/bsg_acm_engine.sv
// bsg_acm_engine: Arnold's Cat Map permutation engine.
// Loads an N x N image over ready/valid, runs a latched number of forward or
// inverse cat-map passes between two ping-pong buffers, then streams the
// result out over valid/yumi.
// Optional: define BSG_ACM_PERF_CTR_EN to add perf_cycles_o / perf_images_o.
//
// state   | meaning
// --------+------------------------------------------------------------
// e_load  | accept pixels into buf[cur]; latch iters/decrypt on beat 0
// e_map   | one pixel per cycle buf[cur][a] -> buf[~cur][f(a)]
// e_drain | present buf[cur][addr] on data_o, advance on yumi_i

module bsg_acm_engine #(
  parameter int board_width_p = 8,
  parameter int pixel_width_p = 8,
  parameter int max_iters_p   = 15,
  localparam int coord_width_lp = (board_width_p > 1) ? $clog2(board_width_p) : 1,
  localparam int addr_width_lp  = ((board_width_p * board_width_p) > 1)
                                  ? $clog2(board_width_p * board_width_p) : 1,
  localparam int iter_width_lp  = ((max_iters_p + 1) > 1) ? $clog2(max_iters_p + 1) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [pixel_width_p-1:0] data_i,
  input  logic                     v_i,
  input  logic [iter_width_lp-1:0] iters_i,
  input  logic                     decrypt_i,
  output logic                     ready_o,
  output logic [pixel_width_p-1:0] data_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic                     busy_o
`ifdef BSG_ACM_PERF_CTR_EN
  , output logic [31:0]            perf_cycles_o
  , output logic [15:0]            perf_images_o
`endif
);

  localparam int nn_lp        = board_width_p * board_width_p;
  localparam int ext_width_lp = coord_width_lp + 2;

  localparam logic [addr_width_lp-1:0]  last_addr_lp  = addr_width_lp'(nn_lp - 1);
  localparam logic [coord_width_lp-1:0] last_coord_lp = coord_width_lp'(board_width_p - 1);
  localparam logic [ext_width_lp-1:0]   n_ext_lp      = ext_width_lp'(board_width_p);
  localparam logic [iter_width_lp-1:0]  max_iters_lp  = iter_width_lp'(max_iters_p);
  localparam logic [iter_width_lp-1:0]  one_iter_lp   = iter_width_lp'(1);

  typedef enum logic [1:0] {
    e_load  = 2'd0,
    e_map   = 2'd1,
    e_drain = 2'd2
  } state_e;

  state_e state_r, state_n;

  logic [addr_width_lp-1:0]  addr_r;
  logic [coord_width_lp-1:0] x_r, y_r;
  logic [iter_width_lp-1:0]  iters_left_r;
  logic                      decrypt_r;
  logic                      cur_r;

  logic [pixel_width_p-1:0]  buf_r [2][nn_lp];

  logic                      load_fire, map_step, drain_fire, addr_adv, addr_last, first_beat;
  logic [iter_width_lp-1:0]  iters_sat;
  logic [ext_width_lp-1:0]   x_ext, y_ext, x_map, y_map;
  logic [addr_width_lp-1:0]  map_addr;
  logic                      buf_we, buf_wsel;
  logic [addr_width_lp-1:0]  buf_waddr;
  logic [pixel_width_p-1:0]  buf_wdata, rd_data;

  assign addr_last  = (addr_r == last_addr_lp);
  assign first_beat = load_fire & (addr_r == '0);
  assign iters_sat  = (iters_i > max_iters_lp) ? max_iters_lp : iters_i;
  assign addr_adv   = load_fire | map_step | drain_fire;

  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_load;
    else         state_r <= state_n;
  end

  // next-state decode and handshake outputs
  always_comb begin
    state_n    = state_r;
    ready_o    = 1'b0;
    v_o        = 1'b0;
    busy_o     = 1'b0;
    load_fire  = 1'b0;
    map_step   = 1'b0;
    drain_fire = 1'b0;
    case (state_r)
      e_load: begin
        // ready is withheld during reset so no beat is counted as captured
        ready_o   = ~reset_i;
        load_fire = v_i & ~reset_i;
        if (load_fire && addr_last)
          state_n = (iters_left_r != '0) ? e_map : e_drain;
      end
      e_map: begin
        busy_o   = 1'b1;
        map_step = 1'b1;
        if (addr_last && (iters_left_r == one_iter_lp))
          state_n = e_drain;
      end
      e_drain: begin
        v_o        = 1'b1;
        drain_fire = yumi_i;
        if (yumi_i && addr_last)
          state_n = e_load;
      end
      default: state_n = e_load;
    endcase
  end

  // raster address with separate x/y so the map needs no divider
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_r       <= '0;
      x_r          <= '0;
      y_r          <= '0;
      iters_left_r <= '0;
      decrypt_r    <= 1'b0;
      cur_r        <= 1'b0;
    end else begin
      if (addr_adv) begin
        if (addr_last) begin
          addr_r <= '0;
          x_r    <= '0;
          y_r    <= '0;
        end else begin
          addr_r <= addr_r + addr_width_lp'(1);
          if (x_r == last_coord_lp) begin
            x_r <= '0;
            y_r <= y_r + coord_width_lp'(1);
          end else begin
            x_r <= x_r + coord_width_lp'(1);
          end
        end
      end
      if (first_beat) begin
        iters_left_r <= iters_sat;
        decrypt_r    <= decrypt_i;
      end
      if (map_step && addr_last) begin
        cur_r        <= ~cur_r;
        iters_left_r <= iters_left_r - one_iter_lp;
      end
    end
  end

  // cat-map destination; inverse terms are biased by +N to stay non-negative,
  // then at most two subtractions of N bring every case back into [0, N)
  always_comb begin
    x_ext = ext_width_lp'(x_r);
    y_ext = ext_width_lp'(y_r);
    if (decrypt_r) begin
      x_map = (x_ext << 1) + n_ext_lp - y_ext;
      y_map = y_ext + n_ext_lp - x_ext;
    end else begin
      x_map = x_ext + y_ext;
      y_map = x_ext + (y_ext << 1);
    end
    if (x_map >= n_ext_lp) x_map = x_map - n_ext_lp;
    if (x_map >= n_ext_lp) x_map = x_map - n_ext_lp;
    if (y_map >= n_ext_lp) y_map = y_map - n_ext_lp;
    if (y_map >= n_ext_lp) y_map = y_map - n_ext_lp;
    map_addr = addr_width_lp'(32'(y_map) * board_width_p + 32'(x_map));
  end

  // single write port shared by load and map
  always_comb begin
    rd_data   = buf_r[cur_r][addr_r];
    buf_we    = (load_fire | map_step) & ~reset_i;
    buf_wsel  = load_fire ? cur_r : ~cur_r;
    buf_waddr = load_fire ? addr_r : map_addr;
    buf_wdata = load_fire ? data_i : rd_data;
  end

  // ping-pong pixel storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (buf_we) buf_r[buf_wsel][buf_waddr] <= buf_wdata;
  end

  assign data_o = rd_data;

`ifdef BSG_ACM_PERF_CTR_EN
  // map-cycle and completed-image counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_cycles_o <= '0;
      perf_images_o <= '0;
    end else begin
      if (first_beat)
        perf_cycles_o <= '0;
      else if (map_step && (perf_cycles_o != '1))
        perf_cycles_o <= perf_cycles_o + 32'd1;
      if (drain_fire && addr_last)
        perf_images_o <= perf_images_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_acm_engine.sv
// Self-checking bench for bsg_acm_engine: N=4 (max 15) and N=5 (max 10)
// instances share stimulus; sel picks which one is driven and observed.
module tb_bsg_acm_engine;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       sel = 1'b0;
  logic       v = 1'b0, yumi = 1'b0, decrypt = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] iters = '0;

  always #5 clk = ~clk;

  logic       ready4, v_o4, busy4, ready5, v_o5, busy5;
  logic [7:0] data_o4, data_o5;
  logic       ready, v_o, busy;
  logic [7:0] data_o;
`ifdef BSG_ACM_PERF_CTR_EN
  logic [31:0] perf_cycles4, perf_cycles5;
  logic [15:0] perf_images4, perf_images5;
`endif

  bsg_acm_engine #(.board_width_p(4), .pixel_width_p(8), .max_iters_p(15)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data), .v_i(v & ~sel), .iters_i(iters),
    .decrypt_i(decrypt), .ready_o(ready4), .data_o(data_o4), .v_o(v_o4),
    .yumi_i(yumi & ~sel), .busy_o(busy4)
`ifdef BSG_ACM_PERF_CTR_EN
    , .perf_cycles_o(perf_cycles4), .perf_images_o(perf_images4)
`endif
  );

  bsg_acm_engine #(.board_width_p(5), .pixel_width_p(8), .max_iters_p(10)) dut5 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data), .v_i(v & sel), .iters_i(iters),
    .decrypt_i(decrypt), .ready_o(ready5), .data_o(data_o5), .v_o(v_o5),
    .yumi_i(yumi & sel), .busy_o(busy5)
`ifdef BSG_ACM_PERF_CTR_EN
    , .perf_cycles_o(perf_cycles5), .perf_images_o(perf_images5)
`endif
  );

  assign ready  = sel ? ready5  : ready4;
  assign v_o    = sel ? v_o5    : v_o4;
  assign busy   = sel ? busy5   : busy4;
  assign data_o = sel ? data_o5 : data_o4;

  int checks = 0;
  int errors = 0;

  logic [7:0] in_img [25];
  logic [7:0] exp_img[25];
  logic [7:0] got_img[25];
  logic [7:0] orig_img[25];

  typedef struct {
    bit sel;
    int iters;
    int eff;
    bit dec;
    bit rnd;
    int duty;
    bit gaps;
    int lat;
    int si0, sv0, si1, sv1, si2, sv2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // reference: out[f(x,y)] = in[x,y], applied it times, plain modular arithmetic
  task automatic model(input int n, input int it, input bit dec);
    int cur[25];
    int nxt[25];
    int xn, yn;
    for (int a = 0; a < 25; a++) begin cur[a] = int'(in_img[a]); nxt[a] = 0; end
    for (int k = 0; k < it; k++) begin
      for (int y = 0; y < n; y++)
        for (int x = 0; x < n; x++) begin
          if (!dec) begin
            xn = (x + y) % n;
            yn = (x + 2 * y) % n;
          end else begin
            xn = (((2 * x - y) % n) + n) % n;
            yn = (((y - x) % n) + n) % n;
          end
          nxt[yn * n + xn] = cur[y * n + x];
        end
      for (int a = 0; a < 25; a++) cur[a] = nxt[a];
    end
    for (int a = 0; a < 25; a++) exp_img[a] = 8'(cur[a]);
  endtask

  // returns at the negedge preceding the last input handshake
  task automatic send_image(input int n, input bit gaps);
    int i, guard;
    i = 0; guard = 0;
    while (i < n * n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (i > 0) begin
        iters   = 4'($urandom);
        decrypt = 1'($urandom);
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        v = 1'b0; data = 8'($urandom);
      end else begin
        v = 1'b1; data = in_img[i];
        if (ready) i++;
      end
    end
    if (guard >= 4000) chk("load_timeout", 0, 1);
  endtask

  task automatic run_image(input int n, input int lat_exp, input int duty, input bit gaps);
    int cnt, busy_cnt, i, guard;
    bit hold;
    logic [7:0] prev;
    send_image(n, gaps);
    @(negedge clk);
    data = 8'($urandom);
    chk("ready_low_after_load", int'(ready), 0);
    cnt = 1;
    busy_cnt = int'(busy);
    while (!v_o && cnt < 3000) begin
      @(negedge clk);
      data = 8'($urandom);
      cnt++;
      if (busy) busy_cnt++;
    end
    chk("first_v_o_latency", cnt, lat_exp);
    chk("busy_cycles", busy_cnt, lat_exp - 1);
    i = 0; guard = 0; hold = 0; prev = '0;
    while (i < n * n && guard < 5000) begin
      guard++;
      chk("v_o_in_drain", int'(v_o), 1);
      chk("ready_low_in_drain", int'(ready), 0);
      if (hold) chk("data_hold", int'(data_o), int'(prev));
      yumi = ($urandom_range(0, 99) < duty);
      if (yumi) begin
        chk($sformatf("pixel[%0d]", i), int'(data_o), int'(exp_img[i]));
        got_img[i] = data_o;
        i++;
      end
      hold = !yumi;
      prev = data_o;
      data = 8'($urandom);
      @(negedge clk);
    end
    if (guard >= 5000) chk("drain_timeout", 0, 1);
    yumi = 1'b0;
    v = 1'b0;
    chk("v_o_after_drain", int'(v_o), 0);
    chk("ready_after_drain", int'(ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    //      sel it eff dec rnd duty gaps lat  spots (idx,val) x3
    vecs[0] = '{0, 1,  1, 0, 0, 100, 0, 17,  5, 1,  9, 4,  0, 0};
    vecs[1] = '{0, 3,  3, 0, 0, 100, 1, 49,  0, 0,  7, 7, 15, 15};
    vecs[2] = '{0, 0,  0, 0, 0, 100, 0, 1,   3, 3, 12, 12, 15, 15};
    vecs[3] = '{1, 13, 10, 0, 1, 100, 1, 251, -1, 0, -1, 0, -1, 0};
    vecs[4] = '{0, 15, 15, 1, 1, 30,  1, 241, -1, 0, -1, 0, -1, 0};
    vecs[5] = '{1, 1,  1, 1, 0, 60,  0, 26,  22, 1,  9, 5,  0, 0};

    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready4_in_reset", int'(ready4), 0);
    chk("ready5_in_reset", int'(ready5), 0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("ready4_after_reset", int'(ready4), 1);
    chk("v_o4_after_reset", int'(v_o4), 0);
    chk("busy4_after_reset", int'(busy4), 0);
    chk("ready5_after_reset", int'(ready5), 1);
`ifdef BSG_ACM_PERF_CTR_EN
    chk("perf_cycles_reset", int'(perf_cycles4), 0);
`endif

    for (int k = 0; k < 6; k++) begin
      sel = vecs[k].sel;
      n = vecs[k].sel ? 5 : 4;
      for (int a = 0; a < 25; a++) in_img[a] = vecs[k].rnd ? 8'($urandom) : 8'(a);
      iters   = 4'(vecs[k].iters);
      decrypt = vecs[k].dec;
      model(n, vecs[k].eff, vecs[k].dec);
      run_image(n, vecs[k].lat, vecs[k].duty, vecs[k].gaps);
      if (vecs[k].si0 >= 0) chk($sformatf("vec%0d_spot0", k), int'(got_img[vecs[k].si0]), vecs[k].sv0);
      if (vecs[k].si1 >= 0) chk($sformatf("vec%0d_spot1", k), int'(got_img[vecs[k].si1]), vecs[k].sv1);
      if (vecs[k].si2 >= 0) chk($sformatf("vec%0d_spot2", k), int'(got_img[vecs[k].si2]), vecs[k].sv2);
    end

    // N=5 round trip: forward 7 then inverse 7 restores the image
    sel = 1'b1;
    for (int a = 0; a < 25; a++) begin in_img[a] = 8'($urandom); orig_img[a] = in_img[a]; end
    iters = 4'd7; decrypt = 1'b0;
    model(5, 7, 1'b0);
    run_image(5, 176, 100, 1'b1);
    for (int a = 0; a < 25; a++) in_img[a] = got_img[a];
    iters = 4'd7; decrypt = 1'b1;
    model(5, 7, 1'b1);
    run_image(5, 176, 70, 1'b0);
    for (int a = 0; a < 25; a++) chk($sformatf("roundtrip[%0d]", a), int'(got_img[a]), int'(orig_img[a]));

    // reset in the middle of MAP, then a clean image
    sel = 1'b0;
    for (int a = 0; a < 25; a++) in_img[a] = 8'($urandom);
    iters = 4'd5; decrypt = 1'b0;
    send_image(4, 1'b0);
    @(negedge clk);
    v = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_mid_map", int'(busy), 1);
    reset_i = 1'b1;
    @(negedge clk);
    chk("ready_during_reset", int'(ready), 0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", int'(ready), 1);
    chk("busy_after_mid_reset", int'(busy), 0);
    chk("v_o_after_mid_reset", int'(v_o), 0);
    for (int a = 0; a < 25; a++) in_img[a] = 8'(a);
    iters = 4'd1; decrypt = 1'b0;
    model(4, 1, 1'b0);
    run_image(4, 17, 100, 1'b0);
    chk("post_reset_spot5", int'(got_img[5]), 1);
    chk("post_reset_spot9", int'(got_img[9]), 4);
`ifdef BSG_ACM_PERF_CTR_EN
    chk("perf_cycles", int'(perf_cycles4), 16);
    chk("perf_images", int'(perf_images4), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
